// File: rtl/vram_pkg.sv
// Shared types and address-map constants for the video-memory arbiter.
package vram_pkg;

  typedef enum logic [2:0] {
    REG_TB  = 3'd0,
    REG_TG  = 3'd1,
    REG_SG  = 3'd2,
    REG_PAL = 3'd3,
    REG_OAM = 3'd4
  } region_e;

  localparam int NUM_REGIONS = 5;
  localparam int DEPTH_TB    = 300;
  localparam int DEPTH_TG    = 2048;
  localparam int DEPTH_SG    = 2048;
  localparam int DEPTH_PAL   = 8;
  localparam int DEPTH_OAM   = 256;

  localparam int OFF_W  = 11;
  localparam int WORD_W = 32;
  localparam int PAL_W  = 24;

  typedef struct packed {
    logic [2:0]        region;
    logic [OFF_W-1:0]  offset;
    logic [WORD_W-1:0] data;
  } wr_entry_t;

  function automatic logic addr_legal(input logic [2:0] region, input logic [OFF_W-1:0] offset);
    case (region)
      REG_TB:  return int'(offset) < DEPTH_TB;
      REG_TG:  return int'(offset) < DEPTH_TG;
      REG_SG:  return int'(offset) < DEPTH_SG;
      REG_PAL: return int'(offset) < DEPTH_PAL;
      REG_OAM: return int'(offset) < DEPTH_OAM;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write FIFO; the caller guarantees no push when full and no pop when empty.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output logic      full,
  output logic      empty,
  output wr_entry_t head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  wr_entry_t   mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates renderer reads and queued host writes across the five video memories.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int NUM_MEM      = 5,
  parameter int AW           = 11,
  parameter int DW           = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [13:0]           host_addr,
  input  logic [DW-1:0]         host_wdata,
  input  logic                  rd_req,
  input  logic [2:0]            rd_region,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DW-1:0]         rd_data,
  input  logic                  vblank,
  output logic                  err_flag,
  input  logic                  err_clear,
  output logic [NUM_MEM-1:0]    mem_rw,
  output logic [NUM_MEM*AW-1:0] mem_addr,
  output logic [NUM_MEM*DW-1:0] mem_wdata,
  input  logic [NUM_MEM*DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE    = 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == STARVE_MAX) ? v : v + CNT_ONE;
  endfunction

  wr_entry_t     din;
  wr_entry_t     head;
  logic          full;
  logic          empty;
  logic          push;
  logic          push_legal;
  logic          enq;
  logic          pop;
  logic          host_win;
  logic          head_blocked;
  logic          rd_legal;
  logic          rd_illegal;
  logic [CW-1:0] starve_cnt;
  logic          vld_p1;
  logic [2:0]    region_p1;
  logic [DW-1:0] rdata_sel;

  assign din          = '{region: host_addr[13:11], offset: host_addr[10:0], data: host_wdata};
  assign host_ready   = !full && !reset;
  assign push         = host_valid && host_ready;
  assign push_legal   = addr_legal(din.region, din.offset);
  assign enq          = push && push_legal;
  assign rd_legal     = int'(rd_region) < NUM_MEM;
  assign rd_illegal   = rd_req && !rd_legal;
  assign host_win     = vblank || (starve_cnt == STARVE_MAX);
  assign head_blocked = rd_req && (rd_region == head.region);
  assign pop          = !reset && !empty && (!head_blocked || host_win);
  // A read loses only to a head write that is forced through to the same memory.
  assign rd_gnt       = !reset && rd_req && rd_legal && !(host_win && !empty && (head.region == rd_region));

  vram_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      err_flag   <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      starve_cnt <= (empty || pop) ? '0 : sat_inc(starve_cnt);
      vld_p1     <= rd_gnt;
      if ((push && !push_legal) || rd_illegal) err_flag <= 1'b1;
      else if (err_clear)                      err_flag <= 1'b0;
    end
  end

  // Stage p1: read issued last cycle, memory data now present on mem_rdata.
  always_ff @(posedge clk) begin
    if (rd_gnt) region_p1 <= rd_region;
  end

  assign rdata_sel = mem_rdata[region_p1*DW +: DW];
  assign rd_valid  = vld_p1 && !reset;

  always_comb begin
    rd_data = '0;
    if (rd_valid) rd_data = (region_p1 == REG_PAL) ? DW'(rdata_sel[PAL_W-1:0]) : rdata_sel;
  end

  always_comb begin
    mem_rw    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pop) begin
      mem_rw[head.region]              = 1'b1;
      mem_addr[head.region*AW +: AW]   = head.offset;
      mem_wdata[head.region*DW +: DW]  = (head.region == REG_PAL) ? DW'(head.data[PAL_W-1:0]) : head.data;
    end
    if (rd_gnt) mem_addr[rd_region*AW +: AW] = rd_addr;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the five single-port video memories between two requesters: host register writes and renderer reads.
- The five memories are tile buffer, tile graphics, sprite graphics, colour palettes and OAM.
- Host writes enter a small FIFO and drain when their target memory is free. Renderer reads get priority, except during vblank and when the starvation guard fires.
- Sits between the Avalon slave decode / video renderer and the memory instances.

Parameters:
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 16, cycles a blocked FIFO head waits before the host is forced through
- NUM_MEM, 5, number of memories arbitrated
- AW, 11, per-memory address bus width (narrower memories use LSBs)
- DW, 32, data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_valid  in  1  host write request
- host_ready  out  1  FIFO not full
- host_addr  in  14  [13:11] region, [10:0] word offset
- host_wdata  in  32  write data
- rd_req  in  1  renderer read request
- rd_region  in  3  target memory of read
- rd_addr  in  11  read word offset
- rd_gnt  out  1  read issued this cycle (combinational)
- rd_valid  out  1  rd_data valid
- rd_data  out  32  read result
- vblank  in  1  host has absolute priority while high
- err_flag  out  1  sticky illegal-address flag
- err_clear  in  1  clears err_flag
- mem_rw  out  NUM_MEM  per-memory write enable (1 = write)
- mem_addr  out  NUM_MEM*AW  per-memory address, memory i at [i*AW +: AW]
- mem_wdata  out  NUM_MEM*DW  per-memory write data
- mem_rdata  in  NUM_MEM*DW  per-memory registered read data

Behaviour:
- Region codes: 0 tile_buffer, 1 tile_graphics, 2 sprite_graphics, 3 palette, 4 OAM.
- Legal offset limits: 300, 2048, 2048, 8, 256 words respectively.
- Push: when host_valid && host_ready, the entry is checked.
  - Legal: enqueued.
  - Illegal (region ≥5 or offset ≥ limit): accepted, discarded, err_flag set.
- host_ready = !full. A push while full is never taken, even if a pop happens the same cycle.
- err_flag: set has priority over a simultaneous err_clear.
- FIFO head blocked = head region == rd_region && rd_req.
- Host win condition: vblank, or starve_cnt == STARVE_LIMIT.
- Head pops (mem_rw[head]=1, address and data driven) when the FIFO is non-empty and either the head is not blocked or the host win condition holds.
- rd_gnt = rd_req && rd_region legal && !(host win && FIFO head region == rd_region). When rd_gnt, mem_addr[rd_region] = rd_addr and mem_rw[rd_region] = 0.
- A read and a write to different memories proceed in the same cycle. Each memory sees at most one operation per cycle.
- Idle memories: rw = 0, addr = 0, wdata = 0.
- Read latency is 1:
  - rd_gnt in cycle N → rd_valid = 1 in cycle N+1.
  - rd_data in N+1 = mem_rdata of the region registered in N.
  - Palette data is zero-extended from 24 bits; palette writes use wdata[23:0].
- Renderer read to an illegal region: rd_gnt = 0 and err_flag is set.
- Write latency: a push in cycle N is at earliest in the memory at the edge ending cycle N+1. There is no FIFO bypass.
- starve_cnt:
  - Increments each cycle the head exists and does not pop, saturating at STARVE_LIMIT.
  - Clears on pop or when the FIFO is empty.
  - The forced host win lasts exactly one pop.
- Writes are strictly in order. The head blocks later entries even if those target free memories.
- Reset:
  - FIFO emptied, starve_cnt = 0, err_flag = 0.
  - rd_valid = 0, rd_data = 0.
  - mem_rw = 0, mem_addr = 0, mem_wdata = 0.
  - rd_gnt = 0 and host_ready = 0 while reset is high.
  - A read granted in the cycle before reset produces no rd_valid. Queued writes are lost.

Decomposition:
- Package vram_pkg:
  - region enum (REG_TB, REG_TG, REG_SG, REG_PAL, REG_OAM)
  - per-region depth constants (300, 2048, 2048, 8, 256)
  - host write entry struct {region, offset, data}
  - legal-address function
- Sub-module vram_wr_fifo: synchronous FIFO of entry structs with push/pop/full/empty/head.

Test Plan:
1. Idle, host writes 0xDEADBEEF to region 1 offset 5, no renderer traffic → mem_rw[1] = 1 with addr 5 one cycle after push; later renderer read of region 1 offset 5 → rd_valid the next cycle, rd_data = 0xDEADBEEF.
2. Renderer reads region 4 every cycle while host writes region 4 offset 3 with vblank = 0 → write stalls exactly 16 cycles, then rd_gnt = 0 for one cycle while OAM[3] is written, then reads resume.
3. Renderer reads region 0 while the host head writes region 2 → both in the same cycle: rd_gnt = 1, mem_rw[2] = 1, mem_rw[0] = 0.
4. vblank = 1, FIFO holding 4 writes to region 3, rd_req to region 3 → rd_gnt = 0 for 4 cycles, host_ready returns to 1 after the first pop, palette entries are correct.
5. Host writes region 0 offset 300, then region 6 → nothing enqueued, err_flag = 1; err_clear and a new illegal push in the same cycle → err_flag stays 1.
6. Fill the FIFO, assert reset for 1 cycle mid-drain with a read in flight → after reset: empty, rd_valid = 0, no further mem_rw pulses, host_ready = 1.
